systolic_array_controller: RTL and testbench

- Sequences one matrix-multiply job on an N x N processing-element mesh.
- Generates diagonally skewed feed enables for the west-edge rows (x operands) and north-edge columns (w operands) over K accumulation beats.
- Honours the mesh stall, counts results from the corner PE and reports completion.
- Sits between the job/command front end and the PE array plus its operand buffers.

---
 rtl/systolic_array_controller_if.sv | 30 +++
 rtl/systolic_array_controller.sv | 120 ++++++++++++
 tb/tb_systolic_array_controller.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_controller_if.sv
// Command/feed bundle between the job front end, the controller and the PE mesh.
// master drives the job request and mesh status; slave is the controller itself.
interface systolic_array_controller_if #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int SW = KW + 4
);
    logic          start;
    logic [KW-1:0] cfg_k;
    logic          abort;
    logic          pe_stall;
    logic          corner_ready;
    logic          busy;
    logic          done;
    logic          feed_valid;
    logic [SW-1:0] feed_step;
    logic [N-1:0]  row_en;
    logic [N-1:0]  col_en;
    logic          acc_clr;

    modport master (
        output start, cfg_k, abort, pe_stall, corner_ready,
        input  busy, done, feed_valid, feed_step, row_en, col_en, acc_clr
    );

    modport slave (
        input  start, cfg_k, abort, pe_stall, corner_ready,
        output busy, done, feed_valid, feed_step, row_en, col_en, acc_clr
    );
endinterface

// File: rtl/systolic_array_controller.sv
// Sequences one matrix-multiply job on an N x N PE mesh: skewed row/column feed
// enables over K beats, stall handling, corner result counting and completion.
module systolic_array_controller #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int SW = KW + 4
) (
    input logic                       clk,
    input logic                       n_rst,
    systolic_array_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [KW-1:0] k_reg, k_next;
    logic [SW-1:0] t_reg, t_next;
    logic [KW-1:0] cnt_reg, cnt_next;

    logic          busy;
    logic          accept;
    logic          feed_valid;
    logic [SW-1:0] last_step;
    logic [KW:0]   cnt_plus;
    logic          cnt_hit;
    logic [N-1:0]  en;

    assign busy       = (state_reg == FEED) || (state_reg == DRAIN);
    assign accept     = bus.start && !bus.abort;
    // Abort and stall both kill the issue in the same cycle they are seen.
    assign feed_valid = (state_reg == FEED) && !bus.abort && !bus.pe_stall;
    assign last_step  = SW'(k_reg) + SW'(N - 2);
    // Completion check sees the pulse arriving this cycle, not just the stored count.
    assign cnt_plus   = {1'b0, cnt_reg} + (KW + 1)'(bus.corner_ready);
    assign cnt_hit    = cnt_plus >= {1'b0, k_reg};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            t_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            t_reg     <= t_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        t_next     = t_reg;
        cnt_next   = cnt_reg;

        if (busy && bus.corner_ready && (cnt_reg != k_reg)) begin
            cnt_next = cnt_reg + KW'(1);
        end

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    k_next     = bus.cfg_k;
                    t_next     = '0;
                    cnt_next   = '0;
                    state_next = (bus.cfg_k != '0) ? FEED : DONE;
                end
            end
            FEED: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (feed_valid) begin
                    // t stops at the last useful step so it never exceeds K+N-2.
                    if (t_reg == last_step) begin
                        state_next = DRAIN;
                    end else begin
                        t_next = t_reg + SW'(1);
                    end
                end
            end
            DRAIN: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (cnt_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Row/column r consumes operand element (t - r) while 0 <= t - r < K.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_en
            localparam logic [SW-1:0] ROW = SW'(gi);
            assign en[gi] = feed_valid && (t_reg >= ROW) && ((t_reg - ROW) < SW'(k_reg));
        end
    endgenerate

    assign bus.busy       = busy;
    assign bus.done       = (state_reg == DONE);
    assign bus.feed_valid = feed_valid;
    assign bus.feed_step  = t_reg;
    assign bus.row_en     = en;
    assign bus.col_en     = en;
    assign bus.acc_clr    = n_rst && (state_reg == IDLE) && accept;

endmodule

// File: tb/tb_systolic_array_controller.sv
// Bench for systolic_array_controller: directed vector table, hand-written
// corner sequences and randomized jobs checked against a job-level model.
module tb_systolic_array_controller;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int SW = KW + 4;
    localparam int MAXC = 512;

    logic clk;
    logic n_rst;

    systolic_array_controller_if #(.N(N), .KW(KW), .SW(SW)) bus ();

    systolic_array_controller #(.N(N), .KW(KW), .SW(SW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit            stall_pat [MAXC];
    bit            cr_pat    [MAXC];
    bit            e_fv      [MAXC];
    logic [N-1:0]  e_en      [MAXC];
    int            e_step    [MAXC];
    int            m_done;
    int            m_last;

    typedef struct {
        int k;
        int stall_c0;
        int stall_len;
        int cr_c0;
        int cr_gap;
        int exp_done;
        int exp_fv;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s c=%0d actual=%h required=%h", name, c, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_obs(input logic a, input logic b, input logic d, input logic f,
                                             input logic [N-1:0] r, input logic [N-1:0] cl,
                                             input logic [SW-1:0] st);
        return 64'({a, b, d, f, r, cl, st});
    endfunction

    function automatic logic [N-1:0] en_mask(input int s, input int k);
        logic [N-1:0] m;
        for (int r = 0; r < N; r++) m[r] = (s >= r) && (s - r < k);
        return m;
    endfunction

    // Job-level model: walk issued steps, then done one cycle after the later
    // of (first drain cycle) and (cycle of the K-th corner pulse).
    task automatic build_model(input int k);
        int s;
        int c;
        int cnt;
        int kth;
        for (int i = 0; i < MAXC; i++) begin
            e_fv[i] = 0; e_en[i] = '0; e_step[i] = 0;
        end
        if (k == 0) begin
            m_done = 1; m_last = 0;
            return;
        end
        s = 0; c = 1; m_last = 1;
        while (s < k + N - 1 && c < MAXC - 4) begin
            e_step[c] = s;
            if (!stall_pat[c]) begin
                e_fv[c] = 1;
                e_en[c] = en_mask(s, k);
                s++;
            end
            m_last = c;
            c++;
        end
        cnt = 0; kth = MAXC - 3;
        for (int i = 1; i < MAXC - 3; i++) begin
            if (cr_pat[i]) cnt++;
            if (cnt == k) begin kth = i; break; end
        end
        m_done = ((m_last + 1 > kth) ? m_last + 1 : kth) + 1;
        if (m_done > MAXC - 2) m_done = MAXC - 2;
        for (int i = m_last + 1; i < m_done; i++) e_step[i] = k + N - 2;
    endtask

    // Called just after a rising edge with the DUT idle.
    task automatic run_job(input int k, output int obs_done, output int obs_fv);
        logic rel;
        obs_done = -1;
        obs_fv   = 0;
        build_model(k);
        for (int c = 0; c <= m_done + 1; c++) begin
            bus.start        = (c == 0);
            bus.cfg_k        = (c == 0) ? KW'(k) : KW'($urandom_range(0, 255));
            bus.abort        = 1'b0;
            bus.pe_stall     = stall_pat[c];
            bus.corner_ready = cr_pat[c];
            @(negedge clk);
            rel = (c >= 1) && (c < m_done);
            chk("cycle", c,
                pack_obs(bus.acc_clr, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en,
                         rel ? bus.feed_step : SW'(0)),
                pack_obs(c == 0, (c >= 1) && (c < m_done), c == m_done, e_fv[c], e_en[c], e_en[c],
                         rel ? SW'(e_step[c]) : SW'(0)));
            if (bus.done && obs_done < 0) obs_done = c;
            if (bus.feed_valid) obs_fv++;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0; bus.pe_stall = 1'b0; bus.corner_ready = 1'b0;
    endtask

    task automatic clear_pats();
        for (int i = 0; i < MAXC; i++) begin stall_pat[i] = 0; cr_pat[i] = 0; end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int od, of;
        int k;

        vecs[0] = '{3, 0, 0, 7, 2, 12, 6};
        vecs[1] = '{3, 3, 2, 7, 2, 12, 6};
        vecs[2] = '{0, 0, 0, 1, 1, 1, 0};
        vecs[3] = '{1, 0, 0, 2, 1, 6, 4};
        vecs[4] = '{5, 2, 3, 3, 3, 16, 8};
        vecs[5] = '{2, 0, 0, 1, 1, 7, 5};

        n_rst = 1'b0;
        bus.start = 1'b0; bus.cfg_k = '0; bus.abort = 1'b0;
        bus.pe_stall = 1'b0; bus.corner_ready = 1'b0;
        #3;
        chk("reset_outputs", 0,
            pack_obs(bus.acc_clr, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en, bus.feed_step),
            64'd0);
        #20;
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle_cycle();

        // Directed vector table.
        for (int v = 0; v < 6; v++) begin
            clear_pats();
            for (int c = 0; c < MAXC; c++) begin
                stall_pat[c] = (c >= vecs[v].stall_c0) && (c < vecs[v].stall_c0 + vecs[v].stall_len);
                cr_pat[c]    = (c >= vecs[v].cr_c0) && ((c - vecs[v].cr_c0) % vecs[v].cr_gap == 0)
                               && ((c - vecs[v].cr_c0) / vecs[v].cr_gap < vecs[v].k);
            end
            run_job(vecs[v].k, od, of);
            chk("done_cycle", v, 64'(od), 64'(vecs[v].exp_done));
            chk("fv_count", v, 64'(of), 64'(vecs[v].exp_fv));
            $display("vector %0d: k=%0d done@%0d feed_steps=%0d", v, vecs[v].k, od, of);
        end

        // Abort during FEED at t=1.
        bus.start = 1'b1; bus.cfg_k = KW'(4);
        @(negedge clk);
        chk("abort_accclr", 0, 64'(bus.acc_clr), 64'd1);
        idle_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort_t0", 1, pack_obs(0, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en, bus.feed_step),
            pack_obs(0, 1, 0, 1, 4'b0001, 4'b0001, SW'(0)));
        idle_cycle();
        bus.abort = 1'b1;
        @(negedge clk);
        chk("abort_t1", 2, pack_obs(0, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en, bus.feed_step),
            pack_obs(0, 1, 0, 0, 4'b0000, 4'b0000, SW'(1)));
        idle_cycle();
        bus.abort = 1'b0;
        for (int c = 3; c < 9; c++) begin
            bus.corner_ready = 1'(c % 2);
            @(negedge clk);
            chk("abort_after", c, pack_obs(bus.acc_clr, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en, 0),
                64'd0);
            idle_cycle();
        end
        bus.corner_ready = 1'b0;
        $display("abort job: cancelled at t=1");

        // Abort wins over start in IDLE.
        bus.start = 1'b1; bus.abort = 1'b1; bus.cfg_k = KW'(2);
        @(negedge clk);
        chk("abort_blocks_accclr", 0, 64'(bus.acc_clr), 64'd0);
        idle_cycle();
        bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_blocks_busy", 1, 64'(bus.busy), 64'd0);
        idle_cycle();

        clear_pats();
        for (int c = 1; c < MAXC; c++) cr_pat[c] = 1;
        run_job(2, od, of);
        chk("post_abort_done", 0, 64'(od), 64'd7);
        $display("post-abort job: k=2 done@%0d", od);

        // start held high continuously, K=1, corner_ready stuck high.
        bus.start = 1'b1; bus.cfg_k = KW'(1); bus.corner_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            chk("b2b", c, 64'({bus.acc_clr, bus.busy, bus.done}),
                64'({(c % 7) == 0, ((c % 7) != 0) && ((c % 7) != 6), (c % 7) == 6}));
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.corner_ready = 1'b0;
        idle_cycle();
        $display("back-to-back: 3 jobs with start held high");

        // Reset in DRAIN.
        bus.start = 1'b1; bus.cfg_k = KW'(3);
        idle_cycle();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) idle_cycle();
        @(negedge clk);
        chk("drain_reached", 7, 64'({bus.busy, bus.feed_valid, bus.feed_step}), 64'({1'b1, 1'b0, SW'(5)}));
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        chk("reset_in_drain", 0,
            pack_obs(bus.acc_clr, bus.busy, bus.done, bus.feed_valid, bus.row_en, bus.col_en, bus.feed_step),
            64'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        bus.corner_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_reset_idle", c, 64'({bus.busy, bus.done, bus.acc_clr}), 64'd0);
            idle_cycle();
        end
        bus.corner_ready = 1'b0;
        $display("reset in drain: job discarded");

        // Randomized jobs against the model.
        for (int j = 0; j < 30; j++) begin
            clear_pats();
            k = $urandom_range(0, 20);
            for (int c = 0; c < MAXC; c++) begin
                stall_pat[c] = (c < 100) && ($urandom_range(0, 3) == 0);
                cr_pat[c]    = (c >= 100) || ($urandom_range(0, 1) == 1);
            end
            run_job(k, od, of);
            chk("rand_fv_count", j, 64'(of), 64'((k == 0) ? 0 : k + N - 1));
            $display("random job %0d: k=%0d done@%0d feed_steps=%0d", j, k, od, of);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
